// File: rtl/led_fade_driver.sv
// led_fade_driver
//
// Purpose:
//   Downstream stage of the 4-bit running-light pattern generator. It takes
//   the raw on/off pattern and drives the board LEDs with PWM. Each channel
//   ramps its brightness toward full-on when its pattern bit is 1 and toward
//   off when it is 0, so hard LED steps turn into smooth cross-fades.
//
// Ports:
//   clock    in   1  system clock (100 MHz)
//   reset    in   1  synchronous, active-high reset
//   led_in   in   4  pattern from upstream, same clock domain
//   led_out  out  4  PWM drive, active-high, registered
//   busy     out  1  high while any channel level differs from its target
//
// Parameters:
//   PWM_BITS   PWM resolution; levels run 0 .. 2**PWM_BITS-1
//   STEP_DIV   clock cycles between brightness steps (>= 1)
//   STEP_SIZE  level change per step (1 .. 2**PWM_BITS-1)
//
// Configuration:
//   LED_FADE_GAMMA_EN  when defined, duty = (level*level) >> PWM_BITS with
//                      full level forced to full duty (square-law curve);
//                      when undefined, duty = level (linear).

module led_fade_driver #(
  parameter int unsigned PWM_BITS  = 8,
  parameter logic [31:0] STEP_DIV  = 32'd100000,
  parameter int unsigned STEP_SIZE = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] led_in,
  output logic [3:0] led_out,
  output logic       busy
);

  localparam int NUM_CH = 4;

  localparam logic [PWM_BITS-1:0] PWM_MAX  = '1;
  // The PWM counter stops one short of PWM_MAX so the period is PWM_MAX
  // cycles and a full level keeps the output constantly high.
  localparam logic [PWM_BITS-1:0] PWM_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [PWM_BITS-1:0] PWM_ONE  = PWM_BITS'(1);
  // Ramp arithmetic is one bit wider than the level so saturation is
  // detected instead of wrapping.
  localparam logic [PWM_BITS:0]   MAX_EXT  = {1'b0, PWM_MAX};
  localparam logic [PWM_BITS:0]   STEP_EXT = (PWM_BITS+1)'(STEP_SIZE);
  localparam logic [31:0]         STEP_LAST = STEP_DIV - 32'd1;

  logic [3:0]          led_in_q,   led_in_d;
  logic [PWM_BITS-1:0] pwm_cnt_q,  pwm_cnt_d;
  logic [31:0]         step_cnt_q, step_cnt_d;
  logic [3:0]          led_out_q,  led_out_d;
  logic                step_tick;
  logic [NUM_CH-1:0]   busy_ch;

  // ---------------------------------------------------------------------
  // Shared counters and input register
  // ---------------------------------------------------------------------
  always_comb begin
    led_in_d   = led_in;
    step_tick  = (step_cnt_q == STEP_LAST);
    step_cnt_d = step_tick ? 32'd0 : step_cnt_q + 32'd1;
    pwm_cnt_d  = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PWM_ONE;
  end

  // NOTE: clocked state is updated with non-blocking assignments so every
  // register samples the values from before the edge, independent of the
  // order of statements or processes.
  always_ff @(posedge clock) begin
    if (reset) begin
      led_in_q   <= '0;
      pwm_cnt_q  <= '0;
      step_cnt_q <= '0;
      led_out_q  <= '0;
    end else begin
      led_in_q   <= led_in_d;
      pwm_cnt_q  <= pwm_cnt_d;
      step_cnt_q <= step_cnt_d;
      led_out_q  <= led_out_d;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel brightness ramp and PWM compare
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS:0]   dn_diff;

    assign target  = led_in_q[g] ? PWM_MAX : '0;
    assign up_sum  = {1'b0, level_q} + STEP_EXT;
    // The top bit of dn_diff is the borrow: set when the step overshoots 0.
    assign dn_diff = {1'b0, level_q} - STEP_EXT;

    always_comb begin
      // NOTE: level_d gets its hold value first so every path through the
      // block assigns it; a missing default here would infer a latch.
      level_d = level_q;
      if (step_tick) begin
        if (level_q < target) begin
          level_d = (up_sum > MAX_EXT) ? PWM_MAX : up_sum[PWM_BITS-1:0];
        end else if (level_q > target) begin
          level_d = dn_diff[PWM_BITS] ? '0 : dn_diff[PWM_BITS-1:0];
        end
      end
    end

`ifdef LED_FADE_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;
    assign level_sq = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
    // Full level is forced to full duty; the square alone tops out below it.
    assign duty = (level_q == PWM_MAX) ? PWM_MAX : level_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign duty = level_q;
`endif

    assign led_out_d[g] = (pwm_cnt_q < duty);
    assign busy_ch[g]   = (level_q != target);

    // NOTE: the level register is reset like any other flop: busy and the
    // PWM output are defined straight out of reset, and a reset mid-ramp
    // must restart the fade from dark.
    always_ff @(posedge clock) begin
      if (reset) begin
        level_q <= '0;
      end else begin
        level_q <= level_d;
      end
    end
  end

  assign led_out = led_out_q;
  assign busy    = |busy_ch;

endmodule

// File: tb/tb_led_fade_driver.sv
// tb_led_fade_driver
//
// Self-checking bench for led_fade_driver with PWM_BITS=4 (PWM_MAX=15).
// Four instances share clock and reset:
//   u_a  STEP_DIV=4,   STEP_SIZE=1  reset, ramp, reversal, mid-ramp reset
//   u_b  STEP_DIV=4,   STEP_SIZE=4  coarse steps and saturation
//   u_c  STEP_DIV=300, STEP_SIZE=5  frozen level 5 duty window
//   u_g  STEP_DIV=300, STEP_SIZE=8  frozen level 8 duty window, 8+8 clamp
// Cycle numbering: cycle n is the n-th rising edge after reset release;
// outputs are sampled 1 time unit after that edge.

module tb_led_fade_driver;

  typedef struct {
    int         inst;  // 0 = u_a, 1 = u_b
    int         cyc;   // cycle at which the row is checked
    logic [3:0] din;   // led_in driven from the previous row until cyc
    int         ch;    // channel whose level is checked
    int         lvl;   // expected level
    logic       bsy;   // expected busy
  } row_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] led_in_a = '0;
  logic [3:0] led_in_b = '0;
  logic [3:0] led_in_c = '0;
  logic [3:0] led_out_a, led_out_b, led_out_c, led_out_g;
  logic       busy_a, busy_b, busy_c, busy_g;
  logic [3:0] lv_a [4];
  logic [3:0] lv_b [4];
  logic [3:0] lv_c [4];
  logic [3:0] lv_g [4];

  int   errors  = 0;
  int   checks  = 0;
  int   cyc_now = 0;
  bit   mono_en = 1'b0;
  int   mono_prev = 0;
  int   mono_viol = 0;
  row_t rows [$];
  int   s_up, s_rev, s_b, s_end;

  always #5 clock = ~clock;

  led_fade_driver #(.PWM_BITS(4), .STEP_DIV(32'd4), .STEP_SIZE(1)) u_a (
    .clock(clock), .reset(reset), .led_in(led_in_a), .led_out(led_out_a), .busy(busy_a));
  led_fade_driver #(.PWM_BITS(4), .STEP_DIV(32'd4), .STEP_SIZE(4)) u_b (
    .clock(clock), .reset(reset), .led_in(led_in_b), .led_out(led_out_b), .busy(busy_b));
  led_fade_driver #(.PWM_BITS(4), .STEP_DIV(32'd300), .STEP_SIZE(5)) u_c (
    .clock(clock), .reset(reset), .led_in(led_in_c), .led_out(led_out_c), .busy(busy_c));
  led_fade_driver #(.PWM_BITS(4), .STEP_DIV(32'd300), .STEP_SIZE(8)) u_g (
    .clock(clock), .reset(reset), .led_in(led_in_c), .led_out(led_out_g), .busy(busy_g));

  for (genvar k = 0; k < 4; k++) begin : g_peek
    assign lv_a[k] = u_a.g_ch[k].level_q;
    assign lv_b[k] = u_b.g_ch[k].level_q;
    assign lv_c[k] = u_c.g_ch[k].level_q;
    assign lv_g[k] = u_g.g_ch[k].level_q;
  end

  // Expected PWM duty for a given level.
  function automatic int duty_of(input int l);
`ifdef LED_FADE_GAMMA_EN
    if (l == 15) return 15;
    return (l * l) >> 4;
`else
    return l;
`endif
  endfunction

  function automatic int lvl_of(input int inst, input int ch);
    if (inst == 0) return int'(lv_a[ch]);
    return int'(lv_b[ch]);
  endfunction

  function automatic int busy_of(input int inst);
    if (inst == 0) return int'(busy_a);
    return int'(busy_b);
  endfunction

  task automatic set_led(input int inst, input logic [3:0] v);
    if (inst == 0) led_in_a = v;
    else           led_in_b = v;
  endtask

  task automatic add(input int inst, input int cyc, input logic [3:0] din,
                     input int ch, input int lvl, input logic bsy);
    row_t r;
    r.inst = inst; r.cyc = cyc; r.din = din; r.ch = ch; r.lvl = lvl; r.bsy = bsy;
    rows.push_back(r);
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc_now++;
  endtask

  task automatic goto(input int c);
    while (cyc_now < c) begin
      step();
      if (mono_en) begin
        if (int'(lv_a[0]) > mono_prev) mono_viol++;
        mono_prev = int'(lv_a[0]);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step();
    reset   = 1'b0;
    cyc_now = 0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      set_led(rows[i].inst, rows[i].din);
      goto(rows[i].cyc);
      check($sformatf("row%0d_cyc%0d_ch%0d_level", i, rows[i].cyc, rows[i].ch),
            lvl_of(rows[i].inst, rows[i].ch), rows[i].lvl);
      check($sformatf("row%0d_cyc%0d_busy", i, rows[i].cyc),
            busy_of(rows[i].inst), int'(rows[i].bsy));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_now);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt_c, cnt_g, exp_c, exp_g;

    // ---- stimulus/expectation table -----------------------------------
    // Ramp up from idle, STEP_SIZE=1: one level per 4 cycles, 15 at cycle 60.
    s_up = rows.size();
    add(0,  1, 4'b0001, 0,  0, 1'b1);
    add(0,  3, 4'b0001, 0,  0, 1'b1);
    add(0,  4, 4'b0001, 0,  1, 1'b1);
    add(0,  7, 4'b0001, 0,  1, 1'b1);
    add(0,  8, 4'b0001, 0,  2, 1'b1);
    add(0, 32, 4'b0001, 0,  8, 1'b1);
    add(0, 32, 4'b0001, 3,  0, 1'b1);
    add(0, 56, 4'b0001, 0, 14, 1'b1);
    add(0, 59, 4'b0001, 0, 14, 1'b1);
    add(0, 60, 4'b0001, 0, 15, 1'b0);
    // Reversal: led_in_q drops on the same edge as the tick that makes 7,
    // so that tick still uses the old value; ramp then falls 1 per tick.
    s_rev = rows.size();
    add(0, 27, 4'b0001, 0,  6, 1'b1);
    add(0, 28, 4'b0000, 0,  7, 1'b1);
    add(0, 31, 4'b0000, 0,  7, 1'b1);
    add(0, 32, 4'b0000, 0,  6, 1'b1);
    add(0, 36, 4'b0000, 0,  5, 1'b1);
    add(0, 52, 4'b0000, 0,  1, 1'b1);
    add(0, 55, 4'b0000, 0,  1, 1'b1);
    add(0, 56, 4'b0000, 0,  0, 1'b0);
    add(0, 60, 4'b0000, 0,  0, 1'b0);
    // STEP_SIZE=4, all channels together: 0,4,8,12,15 then 15,11,7,3,0.
    s_b = rows.size();
    add(1,  3, 4'b1111, 0,  0, 1'b1);
    add(1,  4, 4'b1111, 0,  4, 1'b1);
    add(1,  8, 4'b1111, 0,  8, 1'b1);
    add(1, 12, 4'b1111, 0, 12, 1'b1);
    add(1, 15, 4'b1111, 3, 12, 1'b1);
    add(1, 16, 4'b1111, 0, 15, 1'b0);
    add(1, 16, 4'b1111, 3, 15, 1'b0);
    add(1, 20, 4'b1111, 0, 15, 1'b0);
    add(1, 21, 4'b0000, 0, 15, 1'b1);
    add(1, 24, 4'b0000, 0, 11, 1'b1);
    add(1, 28, 4'b0000, 1,  7, 1'b1);
    add(1, 32, 4'b0000, 0,  3, 1'b1);
    add(1, 35, 4'b0000, 0,  3, 1'b1);
    add(1, 36, 4'b0000, 0,  0, 1'b0);
    add(1, 36, 4'b0000, 2,  0, 1'b0);
    s_end = rows.size();

    // ---- reset held with all pattern bits set -------------------------
    led_in_a = 4'b1111;
    reset    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("reset_led_out", int'(led_out_a), 0);
      check("reset_busy", int'(busy_a), 0);
      check("reset_levels", int'({lv_a[3], lv_a[2], lv_a[1], lv_a[0]}), 0);
    end
    reset   = 1'b0;
    cyc_now = 0;
    check("release_busy_before_edge", int'(busy_a), 0);
    step();
    check("release_busy_after_edge", int'(busy_a), 1);

    // ---- ramp up from idle --------------------------------------------
    led_in_a = 4'b0001;
    do_reset();
    run_rows(s_up, s_rev);
    for (int i = 0; i < 15; i++) begin
      step();
      check($sformatf("full_on_led_out_cyc%0d", cyc_now), int'(led_out_a), 4'b0001);
    end
    check("full_on_busy", int'(busy_a), 0);

    // ---- reversal mid-ramp --------------------------------------------
    led_in_a = 4'b0001;
    do_reset();
    run_rows(s_rev, s_rev + 1);
    mono_en   = 1'b1;
    mono_prev = 7;
    mono_viol = 0;
    run_rows(s_rev + 1, s_b);
    mono_en   = 1'b0;
    check("reversal_monotonic_violations", mono_viol, 0);

    // ---- coarse steps -------------------------------------------------
    led_in_b = 4'b1111;
    do_reset();
    run_rows(s_b, s_end);

    // ---- reset mid-ramp -----------------------------------------------
    led_in_a = 4'b0001;
    do_reset();
    goto(37);
    check("midreset_level_before", int'(lv_a[0]), 9);
    reset = 1'b1;
    step();
    check("midreset_level", int'(lv_a[0]), 0);
    check("midreset_led_out", int'(led_out_a), 0);
    check("midreset_busy", int'(busy_a), 0);
    reset   = 1'b0;
    cyc_now = 0;
    goto(3);
    check("restart_level_cyc3", int'(lv_a[0]), 0);
    goto(4);
    check("restart_level_cyc4", int'(lv_a[0]), 1);
    check("restart_busy", int'(busy_a), 1);

    // ---- frozen levels: duty windows ----------------------------------
    led_in_c = 4'b0001;
    do_reset();
    goto(300);
    check("freeze_c_level", int'(lv_c[0]), 5);
    check("freeze_g_level", int'(lv_g[0]), 8);
    cnt_c = 0;
    cnt_g = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      // Output after edge n reflects the PWM count before that edge, n-1.
      exp_c = (((cyc_now - 1) % 15) < duty_of(5)) ? 1 : 0;
      exp_g = (((cyc_now - 1) % 15) < duty_of(8)) ? 1 : 0;
      check($sformatf("freeze_c_led_out_cyc%0d", cyc_now), int'(led_out_c[0]), exp_c);
      check($sformatf("freeze_g_led_out_cyc%0d", cyc_now), int'(led_out_g[0]), exp_g);
      cnt_c += int'(led_out_c[0]);
      cnt_g += int'(led_out_g[0]);
    end
    check("freeze_c_high_count", cnt_c, 3 * duty_of(5));
    check("freeze_g_high_count", cnt_g, 3 * duty_of(8));
    check("freeze_c_other_channels", int'(led_out_c[3:1]), 0);
    goto(600);
    check("clamp_g_level", int'(lv_g[0]), 15);
    check("step_c_level", int'(lv_c[0]), 10);
    goto(900);
    check("full_c_level", int'(lv_c[0]), 15);
    for (int i = 0; i < 15; i++) begin
      step();
      check($sformatf("full_c_led_out_cyc%0d", cyc_now), int'(led_out_c[0]), 1);
      check($sformatf("full_g_led_out_cyc%0d", cyc_now), int'(led_out_g[0]), 1);
    end
    check("full_c_busy", int'(busy_c), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
